// File: rtl/rvv_backend_pmtrdt_rs.sv
// rvv_backend_pmtrdt_rs: in-order multi-push/multi-pop reservation FIFO feeding the PMTRDT stage
module rvv_backend_pmtrdt_rs #(
  parameter int DEPTH = 8,
  parameter int NPUSH = 2,
  parameter int NPOP = 1,
  parameter int W = 32,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPUSH-1:0]            push_valid,
  input  logic [NPUSH-1:0][W-1:0]     push_data,
  output logic [NPUSH-1:0]            push_ready,
  input  logic [NPOP-1:0]             pop_ex2rs,
  output logic [NPOP-1:0][W-1:0]      pmtrdt_uop_rs2ex,
  output logic                        fifo_empty_rs2ex,
  output logic [NPOP-1:0]             fifo_almost_empty_rs2ex,
  output logic [DEPTH-1:0][W-1:0]     all_uop_data,
  output logic [CW-1:0]               all_uop_cnt,
  input  logic                        trap_flush_rvv
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  int np, nq;
  // Sums never reach 2*DEPTH, so one conditional subtract wraps any DEPTH.
  function automatic logic [PW-1:0] wrap(input int x);
    return PW'(x >= DEPTH ? x - DEPTH : x);
  endfunction
  always_comb begin
    np = 0;
    nq = 0;
    for (int j = 0; j < NPUSH; j++) np = (np == j && push_valid[j] && push_ready[j]) ? j + 1 : np;
    for (int j = 0; j < NPOP; j++) nq = (nq == j && pop_ex2rs[j] && int'(count) > j) ? j + 1 : nq;
  end
  always_ff @(posedge clk) begin
    if (rst || trap_flush_rvv) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= wrap(int'(head) + nq);
      tail <= wrap(int'(tail) + np);
      count <= CW'(int'(count) + np - nq);
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < NPUSH; j++)
      if (!rst && !trap_flush_rvv && j < np) mem[wrap(int'(tail) + j)] <= push_data[j];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(count) <= DEPTH) else $error("rs count overflow");
      assert (np <= DEPTH - int'(count)) else $error("rs write to occupied slot");
    end
  end
  genvar i;
  for (i = 0; i < NPUSH; i++) begin : g_rdy
    assign push_ready[i] = int'(count) + i < DEPTH;
  end
  for (i = 0; i < NPOP; i++) begin : g_pop
    assign pmtrdt_uop_rs2ex[i] = int'(count) > i ? mem[wrap(int'(head) + i)] : '0;
    assign fifo_almost_empty_rs2ex[i] = int'(count) <= i;
  end
  for (i = 0; i < DEPTH; i++) begin : g_all
    assign all_uop_data[i] = int'(count) > i ? mem[wrap(int'(head) + i)] : '0;
  end
  assign fifo_empty_rs2ex = count == '0;
  assign all_uop_cnt = count;
endmodule

// File: tb/tb_rvv_backend_pmtrdt_rs.sv
// tb_rvv_backend_pmtrdt_rs: queue-model scoreboard with directed and random traffic
module tb_rvv_backend_pmtrdt_rs;
  localparam int DEPTH = 8, NPUSH = 2, NPOP = 1, W = 32, CW = 4;
  logic clk = 0;
  logic rst = 1, trap_flush_rvv = 0;
  logic [NPUSH-1:0] push_valid = '0, push_ready;
  logic [NPUSH-1:0][W-1:0] push_data = '0;
  logic [NPOP-1:0] pop_ex2rs = '0, fifo_almost_empty_rs2ex;
  logic [NPOP-1:0][W-1:0] pmtrdt_uop_rs2ex;
  logic fifo_empty_rs2ex;
  logic [DEPTH-1:0][W-1:0] all_uop_data;
  logic [CW-1:0] all_uop_cnt;
  always #5 clk = ~clk;
  rvv_backend_pmtrdt_rs #(.DEPTH(DEPTH), .NPUSH(NPUSH), .NPOP(NPOP), .W(W)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_ex2rs(pop_ex2rs), .pmtrdt_uop_rs2ex(pmtrdt_uop_rs2ex), .fifo_empty_rs2ex(fifo_empty_rs2ex),
    .fifo_almost_empty_rs2ex(fifo_almost_empty_rs2ex), .all_uop_data(all_uop_data),
    .all_uop_cnt(all_uop_cnt), .trap_flush_rvv(trap_flush_rvv));
  typedef struct {
    int cnt;
    logic [DEPTH-1:0][W-1:0] data;
  } snap_t;
  snap_t exp_q[$];
  logic [W-1:0] model[$];
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t s;
      s = exp_q.pop_front();
      chk("cnt", W'(all_uop_cnt), W'(s.cnt));
      chk("empty", W'(fifo_empty_rs2ex), W'(s.cnt == 0));
      for (int i = 0; i < NPUSH; i++) chk($sformatf("push_ready[%0d]", i), W'(push_ready[i]), W'(DEPTH - s.cnt > i));
      for (int i = 0; i < NPOP; i++) begin
        chk($sformatf("almost_empty[%0d]", i), W'(fifo_almost_empty_rs2ex[i]), W'(s.cnt <= i));
        chk($sformatf("uop_out[%0d]", i), pmtrdt_uop_rs2ex[i], s.data[i]);
      end
      for (int k = 0; k < DEPTH; k++) chk($sformatf("all_data[%0d]", k), all_uop_data[k], s.data[k]);
    end
  end
  task automatic step(input bit r, input bit f, input logic [NPUSH-1:0] pv,
                      input logic [NPUSH-1:0][W-1:0] pd, input logic [NPOP-1:0] pp);
    snap_t s;
    int n, p, q;
    @(negedge clk);
    #1;
    rst = r;
    trap_flush_rvv = f;
    push_valid = pv;
    push_data = pd;
    pop_ex2rs = pp;
    @(posedge clk);
    if (r || f) model.delete();
    else begin
      n = model.size();
      p = 0;
      q = 0;
      for (int j = 0; j < NPUSH; j++) if (p == j && pv[j] && DEPTH - n > j) p++;
      for (int j = 0; j < NPOP; j++) if (q == j && pp[j] && n > j) q++;
      repeat (q) void'(model.pop_front());
      for (int j = 0; j < p; j++) model.push_back(pd[j]);
    end
    s.cnt = model.size();
    for (int k = 0; k < DEPTH; k++) s.data[k] = k < model.size() ? model[k] : '0;
    exp_q.push_back(s);
  endtask
  task automatic push2(input logic [W-1:0] a, input logic [W-1:0] b);
    step(0, 0, 2'b11, {b, a}, 1'b0);
  endtask
  initial begin
    step(1, 0, '0, '0, '0);
    push2(32'hA, 32'hB);
    step(0, 0, '0, '0, '0);
    step(1, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) push2(W'(2 * i + 1), W'(2 * i + 2));
    step(0, 0, 2'b11, {32'hEE, 32'hDD}, '0);
    step(0, 0, 2'b01, {32'h0, 32'hDD}, 1'b1);
    step(0, 0, 2'b10, {32'hC, 32'h0}, '0);
    step(1, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) push2(W'(16 + 2 * i), W'(17 + 2 * i));
    repeat (6) step(0, 0, '0, '0, 1'b1);
    push2(32'h57, 32'h58);
    push2(32'h59, 32'h5A);
    step(0, 0, '0, '0, 1'b1);
    step(0, 0, 2'b11, {32'h71, 32'h70}, 1'b1);
    step(0, 0, '0, '0, '0);
    push2(32'h81, 32'h82);
    step(0, 0, 2'b11, {32'h84, 32'h83}, 1'b1);
    step(0, 0, '0, '0, '0);
    push2(32'h91, 32'h92);
    step(1, 0, 2'b11, {32'h94, 32'h93}, 1'b1);
    step(0, 0, '0, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 100) % 2;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, NPUSH'($urandom),
           {$urandom, $urandom}, NPOP'(ph ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
